// File: rtl/sec32_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sec32_pkg: widths, check-bit masks and FSM states for the SEC code    |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
package sec32_pkg;

    localparam int SEC_DATA_W = 32;
    localparam int SEC_CHK_W  = 8;

    // Bit k of the check field is the parity of the data bits selected by SEC_MASK[k]
    localparam logic [SEC_DATA_W-1:0] SEC_MASK [0:SEC_CHK_W-1] = '{
        32'h00FF1111, 32'hFF002222, 32'h0F0F4444, 32'hF0F08888,
        32'h111100FF, 32'h2222FF00, 32'h44440F0F, 32'h8888F0F0
    };

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACC  = 2'd1,
        ST_DONE = 2'd2
    } sec_state_t;

endpackage
`default_nettype wire

// File: rtl/sec32_byte_parity.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sec32_byte_parity: check-field contribution of one data byte          |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module sec32_byte_parity
    import sec32_pkg::*;
(
    input  logic [7:0]            data_byte,
    input  logic [1:0]            byte_idx,
    input  logic [SEC_DATA_W-1:0] masks [0:SEC_CHK_W-1],
    output logic [SEC_CHK_W-1:0]  contrib
);

    logic [4:0] w_base;

    assign w_base = {byte_idx, 3'b000};

    generate
        for (genvar g = 0; g < SEC_CHK_W; g++) begin : g_bit
            assign contrib[g] = ^(data_byte & masks[g][w_base +: 8]);
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/sec32_encoder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sec32_encoder: byte-serial SEC check-bit encoder, valid/ready I/O     |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module sec32_encoder
    import sec32_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [SEC_DATA_W-1:0] in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [SEC_DATA_W-1:0] out_data,
    output logic [SEC_CHK_W-1:0]  out_check,
    output logic                  busy
);

    sec_state_t            r_state;
    logic [1:0]            r_cnt;
    logic [SEC_CHK_W-1:0]  r_acc;
    logic [SEC_DATA_W-1:0] w_masks [0:SEC_CHK_W-1];
    logic [SEC_CHK_W-1:0]  w_contrib;
    logic [7:0]            w_byte;

    generate
        for (genvar g = 0; g < SEC_CHK_W; g++) begin : g_masks
            assign w_masks[g] = SEC_MASK[g];
        end
    endgenerate

    // The latched word is folded in from its own register, so in_data is free after accept
    assign w_byte = out_data[{r_cnt, 3'b000} +: 8];

    sec32_byte_parity u_byte_parity (
        .data_byte (w_byte),
        .byte_idx  (r_cnt),
        .masks     (w_masks),
        .contrib   (w_contrib)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_cnt     <= 2'd0;
            r_acc     <= '0;
            out_data  <= '0;
            out_check <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (in_valid) begin
                        out_data <= in_data;
                        r_acc    <= '0;
                        r_cnt    <= 2'd0;
                        r_state  <= ST_ACC;
                    end
                end
                ST_ACC: begin
                    r_acc <= r_acc ^ w_contrib;
                    r_cnt <= r_cnt + 2'd1;
                    if (r_cnt == 2'd3) begin
                        out_check <= r_acc ^ w_contrib;
                        r_state   <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign in_ready  = (r_state == ST_IDLE);
    assign out_valid = (r_state == ST_DONE);
    assign busy      = (r_state == ST_ACC) || (r_state == ST_DONE);

endmodule
`default_nettype wire
